// File: rtl/eth_tx_framer.sv
// eth_tx_framer: GMII transmit MAC framer feeding gmii_to_rgmii.
// Builds preamble, SFD, payload, zero pad and FCS, then holds the inter-frame gap.
// Define ETH_TX_FCS_EN to build the CRC-32 generator and append the FCS; without it
// frames end after the last payload/pad byte (host supplies its own FCS).
`timescale 1ns/1ps
module eth_tx_framer #(
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned MIN_FRAME  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } state_t;

    localparam logic [10:0] BYTE_MAX = 11'd2047;
    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
    // Outputs lag state by one cycle, so the IDLE cycle that samples in_valid
    // supplies the last idle gap cycle; the IFG state itself is one cycle shorter.
    localparam logic [7:0]  IFG_LAST  = (IFG_CYCLES > 2) ? 8'(IFG_CYCLES - 2) : 8'd0;
    localparam state_t      GAP_STATE = (IFG_CYCLES > 1) ? ST_IFG : ST_IDLE;
`ifdef ETH_TX_FCS_EN
    localparam state_t      TAIL_STATE = ST_FCS;
`else
    localparam state_t      TAIL_STATE = GAP_STATE;
`endif

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [10:0] byte_inc;
    logic [7:0]  txd_d;
    logic        tx_en_d;
    logic        tx_er_d;

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc_q, crc_d;

    // IEEE 802.3 CRC-32, reflected form, one byte per call
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction
`endif

    assign byte_inc = (byte_cnt_q == BYTE_MAX) ? byte_cnt_q : byte_cnt_q + 11'd1;

    // Next-state, counter, CRC and next-output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        txd_d      = '0;
        tx_en_d    = 1'b0;
        tx_er_d    = 1'b0;
`ifdef ETH_TX_FCS_EN
        crc_d      = crc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                byte_cnt_d = '0;
`ifdef ETH_TX_FCS_EN
                crc_d      = '1;
`endif
                if (in_valid) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                tx_en_d = 1'b1;
                txd_d   = 8'h55;
                if (cnt_q == 8'd6) begin
                    cnt_d   = '0;
                    state_d = ST_SFD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SFD: begin
                tx_en_d = 1'b1;
                txd_d   = 8'hD5;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_en_d = 1'b1;
                if (in_valid) begin
                    txd_d      = in_data;
                    byte_cnt_d = byte_inc;
`ifdef ETH_TX_FCS_EN
                    crc_d      = crc_next(crc_q, in_data);
`endif
                    if (in_last) begin
                        cnt_d   = '0;
                        state_d = (byte_inc < MIN_LEN) ? ST_PAD : TAIL_STATE;
                    end
                end else begin
                    // underrun: one error cycle, then straight to the gap
                    tx_er_d = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP_STATE;
                end
            end
            ST_PAD: begin
                tx_en_d    = 1'b1;
                byte_cnt_d = byte_inc;
`ifdef ETH_TX_FCS_EN
                crc_d      = crc_next(crc_q, 8'h00);
`endif
                if (byte_inc >= MIN_LEN) begin
                    cnt_d   = '0;
                    state_d = TAIL_STATE;
                end
            end
`ifdef ETH_TX_FCS_EN
            ST_FCS: begin
                tx_en_d = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    txd_d = ~crc_q[7:0];
                    2'd1:    txd_d = ~crc_q[15:8];
                    2'd2:    txd_d = ~crc_q[23:16];
                    default: txd_d = ~crc_q[31:24];
                endcase
                if (cnt_q[1:0] == 2'd3) begin
                    cnt_d   = '0;
                    state_d = GAP_STATE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            ST_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered GMII/handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            gmii_txd   <= '0;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
`ifdef ETH_TX_FCS_EN
            crc_q      <= '1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            gmii_txd   <= txd_d;
            gmii_tx_en <= tx_en_d;
            gmii_tx_er <= tx_er_d;
            in_ready   <= (state_d == ST_DATA);
            busy       <= (state_d != ST_IDLE);
`ifdef ETH_TX_FCS_EN
            crc_q      <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: directed checks of eth_tx_framer with MIN_FRAME=0 and MIN_FRAME=60.
// FCS expectations follow ETH_TX_FCS_EN, matching the RTL build.
`timescale 1ns/1ps
module tb_eth_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_last;
    logic       v0, v1;
    logic       rdy0, rdy1, en0, en1, er0, er1, busy0, busy1;
    logic [7:0] txd0, txd1;
    logic       sel;
    logic       obs_rdy, obs_en, obs_er;
    logic [7:0] obs_txd;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic       en;
        logic       er;
        logic [7:0] d;
    } smp_t;

    smp_t       cap[$];
    logic       cap_on = 1'b0;
    logic [7:0] pl [0:255];
    logic [7:0] exp_q[$];

    eth_tx_framer #(.IFG_CYCLES(12), .MIN_FRAME(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v0), .in_last(in_last),
        .in_ready(rdy0), .gmii_txd(txd0), .gmii_tx_en(en0), .gmii_tx_er(er0), .busy(busy0)
    );

    eth_tx_framer #(.IFG_CYCLES(12), .MIN_FRAME(60)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v1), .in_last(in_last),
        .in_ready(rdy1), .gmii_txd(txd1), .gmii_tx_en(en1), .gmii_tx_er(er1), .busy(busy1)
    );

    assign obs_rdy = sel ? rdy1 : rdy0;
    assign obs_en  = sel ? en1  : en0;
    assign obs_er  = sel ? er1  : er0;
    assign obs_txd = sel ? txd1 : txd0;

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cap_on) cap.push_back('{cyc: cyc, en: obs_en, er: obs_er, d: obs_txd});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic set_valid(input logic b);
        v0 = sel ? 1'b0 : b;
        v1 = sel ? b : 1'b0;
    endtask

    // Offer pl[0..n-1] on the handshake; drop valid after drop_at accepted bytes (-1: never)
    task automatic send(input int n, input int drop_at, input bit hold);
        int idx;
        int guard;
        bit acc;
        idx = 0;
        guard = 0;
        in_data = pl[0];
        in_last = (n == 1);
        set_valid(1'b1);
        while (idx < n && idx != drop_at) begin
            acc = obs_rdy;
            @(negedge clk);
            guard++;
            if (acc) begin
                idx++;
                if (idx < n) begin
                    in_data = pl[idx];
                    in_last = (idx == n - 1);
                end
            end
            if (guard > 4000) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: accepted %0d of %0d bytes", idx, n);
                set_valid(1'b0);
                return;
            end
        end
        in_last = 1'b0;
        if (idx == drop_at || !hold) set_valid(1'b0);
    endtask

    // Reference frame: preamble, SFD, payload, zero pad, bit-serial CRC-32 FCS
    task automatic build_expected(input int n, input int minf);
        int total;
        logic [7:0] b;
`ifdef ETH_TX_FCS_EN
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
`endif
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        total = (n < minf) ? minf : n;
        for (int i = 0; i < total; i++) begin
            b = (i < n) ? pl[i] : 8'h00;
            exp_q.push_back(b);
`ifdef ETH_TX_FCS_EN
            for (int j = 0; j < 8; j++) begin
                if (c[0] ^ b[j]) c = (c >> 1) ^ 32'hEDB8_8320;
                else             c = c >> 1;
            end
`endif
        end
`ifdef ETH_TX_FCS_EN
        c = ~c;
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[23:16]);
        exp_q.push_back(c[31:24]);
`endif
    endtask

    function automatic int first_en(input int from);
        for (int i = from; i < cap.size(); i++) begin
            if (cap[i].en) return i;
        end
        return -1;
    endfunction

    function automatic int run_len(input int from);
        int n = 0;
        for (int i = from; i < cap.size() && cap[i].en; i++) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({en0, er0, txd0, rdy0, busy0, en1, er1, txd1, rdy1, busy1} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: dut0 en=%b er=%b txd=%02h rdy=%b busy=%b dut1 en=%b er=%b txd=%02h rdy=%b busy=%b, expected all 0",
                     en0, er0, txd0, rdy0, busy0, en1, er1, txd1, rdy1, busy1);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({en0, er0, txd0, rdy0, busy0} !== '0) begin
                n_fail++;
                $display("FAIL idle0 cycle %0d: en=%b er=%b txd=%02h rdy=%b busy=%b, expected all 0",
                         i, en0, er0, txd0, rdy0, busy0);
            end
            n_checks++;
            if ({en1, er1, txd1, rdy1, busy1} !== '0) begin
                n_fail++;
                $display("FAIL idle1 cycle %0d: en=%b er=%b txd=%02h rdy=%b busy=%b, expected all 0",
                         i, en1, er1, txd1, rdy1, busy1);
            end
        end
    endtask

    task automatic test_crc_vector();
        int t0, fi, len;
        sel = 1'b0;
        for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
`ifdef ETH_TX_FCS_EN
        exp_q.push_back(8'h26);
        exp_q.push_back(8'h39);
        exp_q.push_back(8'hF4);
        exp_q.push_back(8'hCB);
`endif
        cap.delete();
        cap_on = 1'b1;
        @(negedge clk);
        t0 = cyc;
        send(9, -1, 1'b0);
        repeat (30) @(negedge clk);
        cap_on = 1'b0;
        fi = first_en(0);
        n_checks++;
        if (fi < 0) begin
            n_fail++;
            $display("FAIL crc_vec_start: no tx_en observed, expected a frame");
        end else begin
            n_checks++;
            if (cap[fi].cyc - t0 !== 2) begin
                n_fail++;
                $display("FAIL crc_vec_latency: first tx_en %0d edges after valid, expected 2", cap[fi].cyc - t0);
            end
            len = run_len(fi);
            n_checks++;
            if (len !== exp_q.size()) begin
                n_fail++;
                $display("FAIL crc_vec_len: tx_en high %0d cycles, expected %0d", len, exp_q.size());
            end
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if ({cap[fi+k].en, cap[fi+k].er, cap[fi+k].d} !== {1'b1, 1'b0, exp_q[k]}) begin
                    n_fail++;
                    $display("FAIL crc_vec_byte %0d: en=%b er=%b txd=%02h, expected en=1 er=0 txd=%02h",
                             k, cap[fi+k].en, cap[fi+k].er, cap[fi+k].d, exp_q[k]);
                end
            end
            for (int k = 0; k < 12; k++) begin
                n_checks++;
                if ({cap[fi+exp_q.size()+k].en, cap[fi+exp_q.size()+k].d} !== 9'h000) begin
                    n_fail++;
                    $display("FAIL crc_vec_ifg %0d: en=%b txd=%02h, expected en=0 txd=00",
                             k, cap[fi+exp_q.size()+k].en, cap[fi+exp_q.size()+k].d);
                end
            end
        end
    endtask

    task automatic test_pad();
        int fi, len;
        sel = 1'b1;
        for (int i = 0; i < 14; i++) pl[i] = 8'hA0 + 8'(i);
        exp_q.delete();
        build_expected(14, 60);
        cap.delete();
        cap_on = 1'b1;
        @(negedge clk);
        send(14, -1, 1'b0);
        repeat (80) @(negedge clk);
        cap_on = 1'b0;
        fi = first_en(0);
        n_checks++;
        if (fi < 0) begin
            n_fail++;
            $display("FAIL pad_start: no tx_en observed, expected a frame");
        end else begin
            len = run_len(fi);
            n_checks++;
`ifdef ETH_TX_FCS_EN
            if (len !== 72) begin
                n_fail++;
                $display("FAIL pad_len: tx_en high %0d cycles, expected 72", len);
            end
`else
            if (len !== 68) begin
                n_fail++;
                $display("FAIL pad_len: tx_en high %0d cycles, expected 68", len);
            end
`endif
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if ({cap[fi+k].en, cap[fi+k].er, cap[fi+k].d} !== {1'b1, 1'b0, exp_q[k]}) begin
                    n_fail++;
                    $display("FAIL pad_byte %0d: en=%b er=%b txd=%02h, expected en=1 er=0 txd=%02h",
                             k, cap[fi+k].en, cap[fi+k].er, cap[fi+k].d, exp_q[k]);
                end
            end
            for (int k = 0; k < 12; k++) begin
                n_checks++;
                if (cap[fi+exp_q.size()+k].en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pad_ifg %0d: en=%b, expected 0", k, cap[fi+exp_q.size()+k].en);
                end
            end
        end
    endtask

    task automatic test_underrun();
        int fi, len;
        sel = 1'b1;
        for (int i = 0; i < 32; i++) pl[i] = 8'h40 + 8'(i);
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 20; i++) exp_q.push_back(pl[i]);
        cap.delete();
        cap_on = 1'b1;
        @(negedge clk);
        send(32, 20, 1'b0);
        repeat (30) @(negedge clk);
        cap_on = 1'b0;
        fi = first_en(0);
        n_checks++;
        if (fi < 0) begin
            n_fail++;
            $display("FAIL underrun_start: no tx_en observed, expected a frame");
        end else begin
            for (int k = 0; k < 28; k++) begin
                n_checks++;
                if ({cap[fi+k].en, cap[fi+k].er, cap[fi+k].d} !== {1'b1, 1'b0, exp_q[k]}) begin
                    n_fail++;
                    $display("FAIL underrun_byte %0d: en=%b er=%b txd=%02h, expected en=1 er=0 txd=%02h",
                             k, cap[fi+k].en, cap[fi+k].er, cap[fi+k].d, exp_q[k]);
                end
            end
            n_checks++;
            if ({cap[fi+28].en, cap[fi+28].er, cap[fi+28].d} !== 10'h300) begin
                n_fail++;
                $display("FAIL underrun_err: en=%b er=%b txd=%02h, expected en=1 er=1 txd=00",
                         cap[fi+28].en, cap[fi+28].er, cap[fi+28].d);
            end
            len = run_len(fi);
            n_checks++;
            if (len !== 29) begin
                n_fail++;
                $display("FAIL underrun_len: tx_en high %0d cycles, expected 29", len);
            end
            for (int k = 0; k < 12; k++) begin
                n_checks++;
                if ({cap[fi+29+k].en, cap[fi+29+k].er} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL underrun_ifg %0d: en=%b er=%b, expected 0 0",
                             k, cap[fi+29+k].en, cap[fi+29+k].er);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int fa, la, fb, len;
        logic [7:0] exp_a[$];
        sel = 1'b1;
        for (int i = 0; i < 64; i++) pl[i] = 8'(i);
        exp_q.delete();
        build_expected(64, 60);
        exp_a = exp_q;
        cap.delete();
        cap_on = 1'b1;
        @(negedge clk);
        send(64, -1, 1'b1);
        for (int i = 0; i < 64; i++) pl[i] = 8'hFF - 8'(i);
        exp_q.delete();
        build_expected(64, 60);
        send(64, -1, 1'b0);
        repeat (30) @(negedge clk);
        cap_on = 1'b0;
        fa = first_en(0);
        n_checks++;
        if (fa < 0) begin
            n_fail++;
            $display("FAIL b2b_start: no tx_en observed, expected two frames");
        end else begin
            len = run_len(fa);
            n_checks++;
            if (len !== exp_a.size()) begin
                n_fail++;
                $display("FAIL b2b_len_a: tx_en high %0d cycles, expected %0d", len, exp_a.size());
            end
            for (int k = 0; k < exp_a.size(); k++) begin
                n_checks++;
                if ({cap[fa+k].en, cap[fa+k].er, cap[fa+k].d} !== {1'b1, 1'b0, exp_a[k]}) begin
                    n_fail++;
                    $display("FAIL b2b_a_byte %0d: en=%b er=%b txd=%02h, expected en=1 er=0 txd=%02h",
                             k, cap[fa+k].en, cap[fa+k].er, cap[fa+k].d, exp_a[k]);
                end
            end
            la = fa + len - 1;
            fb = first_en(la + 1);
            n_checks++;
            if (fb < 0) begin
                n_fail++;
                $display("FAIL b2b_second: no second frame observed, expected one");
            end else begin
                n_checks++;
                if (cap[fb].cyc - cap[la].cyc !== 13) begin
                    n_fail++;
                    $display("FAIL b2b_gap: second preamble %0d cycles after last byte, expected 13",
                             cap[fb].cyc - cap[la].cyc);
                end
                len = run_len(fb);
                n_checks++;
                if (len !== exp_q.size()) begin
                    n_fail++;
                    $display("FAIL b2b_len_b: tx_en high %0d cycles, expected %0d", len, exp_q.size());
                end
                for (int k = 0; k < exp_q.size(); k++) begin
                    n_checks++;
                    if ({cap[fb+k].en, cap[fb+k].er, cap[fb+k].d} !== {1'b1, 1'b0, exp_q[k]}) begin
                        n_fail++;
                        $display("FAIL b2b_b_byte %0d: en=%b er=%b txd=%02h, expected en=1 er=0 txd=%02h",
                                 k, cap[fb+k].en, cap[fb+k].er, cap[fb+k].d, exp_q[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_pad();
        int fi, len;
        sel = 1'b1;
        for (int i = 0; i < 10; i++) pl[i] = 8'h77 ^ 8'(i);
        send(10, -1, 1'b0);
        repeat (5) @(negedge clk);
        n_checks++;
        if ({en1, er1, txd1} !== 10'h200) begin
            n_fail++;
            $display("FAIL pad_before_reset: en=%b er=%b txd=%02h, expected en=1 er=0 txd=00", en1, er1, txd1);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({en1, er1, txd1, rdy1, busy1} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: en=%b er=%b txd=%02h rdy=%b busy=%b, expected all 0",
                     en1, er1, txd1, rdy1, busy1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 14; i++) pl[i] = 8'hC3 + 8'(3 * i);
        exp_q.delete();
        build_expected(14, 60);
        cap.delete();
        cap_on = 1'b1;
        @(negedge clk);
        send(14, -1, 1'b0);
        repeat (80) @(negedge clk);
        cap_on = 1'b0;
        fi = first_en(0);
        n_checks++;
        if (fi < 0) begin
            n_fail++;
            $display("FAIL post_reset_start: no tx_en observed, expected a frame");
        end else begin
            len = run_len(fi);
            n_checks++;
            if (len !== exp_q.size()) begin
                n_fail++;
                $display("FAIL post_reset_len: tx_en high %0d cycles, expected %0d", len, exp_q.size());
            end
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if ({cap[fi+k].en, cap[fi+k].er, cap[fi+k].d} !== {1'b1, 1'b0, exp_q[k]}) begin
                    n_fail++;
                    $display("FAIL post_reset_byte %0d: en=%b er=%b txd=%02h, expected en=1 er=0 txd=%02h",
                             k, cap[fi+k].en, cap[fi+k].er, cap[fi+k].d, exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_crc_vector();
        test_pad();
        test_underrun();
        test_back_to_back();
        test_reset_mid_pad();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
